// File: rtl/keccak_pkg.sv
// Keccak shared definitions: domain separators, pad terminator and padder FSM state.
package keccak_pkg;

    localparam logic [7:0] DS_SHAKE      = 8'h1F;
    localparam logic [7:0] DS_SHA3       = 8'h06;
    localparam logic [7:0] PAD_TERM_BYTE = 8'h80;

    typedef enum logic {
        PAD_ABSORB,
        PAD_FILL
    } pad_state_t;

endpackage

// File: rtl/keccak_stream_padder_lane_builder.sv
// Combinational pad10*1 lane builder: keeps the top n bytes, places DS below them,
// clears the rest and optionally ORs the 0x80 terminator into lane 0.
module pad_lane_builder
    import keccak_pkg::*;
#(
    parameter int W  = 64,
    parameter int BW = $clog2(W / 8)
) (
    input  logic [W-1:0] data,
    input  logic [BW:0]  n,
    input  logic [7:0]   ds,
    input  logic         insert_ds,
    input  logic         insert_term,
    output logic [W-1:0] padded
);

    localparam int NB = W / 8;

    always_comb begin
        padded = '0;
        for (int i = 0; i < NB; i++) begin
            if (i + int'(n) >= NB) begin
                padded[8*i +: 8] = data[8*i +: 8];
            end else if (insert_ds && (i + int'(n) == NB - 1)) begin
                padded[8*i +: 8] = ds;
            end
        end
        if (insert_term) begin
            padded[7:0] = padded[7:0] | PAD_TERM_BYTE;
        end
    end

endmodule

// File: rtl/keccak_stream_padder.sv
// Streaming pad10*1 padder between message input and the Keccak absorb datapath.
// Optional PAD_MODE_SEL_EN adds mode_sha3 to choose DS per message.
module keccak_stream_padder
    import keccak_pkg::*;
#(
    parameter int         W          = 64,
    parameter int         RATE_WORDS = 17,
    parameter logic [7:0] DS_BYTE    = 8'h1F
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [W-1:0]                in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [$clog2(W/8):0]        in_bytes,
`ifdef PAD_MODE_SEL_EN
    input  logic                        mode_sha3,
`endif
    output logic [W-1:0]                out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_block_end,
    output logic                        out_last_block
);

    localparam int              NB       = W / 8;
    localparam int              BW       = $clog2(NB);
    localparam int              CW       = $clog2(RATE_WORDS);
    localparam logic [BW:0]     FULL_N   = (BW + 1)'(NB);
    localparam logic [CW-1:0]   LAST_CNT = CW'(RATE_WORDS - 1);

    pad_state_t    state_q, state_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic          ds_done_q, ds_done_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_block_end_q, out_block_end_d;
    logic          out_last_block_q, out_last_block_d;

    logic          load;
    logic          accept;
    logic          at_end;
    logic          last_partial;
    logic [CW-1:0] cnt_next;
    logic [7:0]    ds_cur;

    logic [W-1:0]  b_data;
    logic [BW:0]   b_n;
    logic          b_ins_ds;
    logic          b_term;
    logic [W-1:0]  padded;

`ifdef PAD_MODE_SEL_EN
    logic [7:0]    ds_q, ds_d;
    logic          msg_start_q, msg_start_d;

    // The first beat of a message uses the live selection; later beats the latched one.
    assign ds_cur = msg_start_q ? (mode_sha3 ? DS_SHA3 : DS_SHAKE) : ds_q;
`else
    assign ds_cur = DS_BYTE;
`endif

    assign load         = !out_valid_q || out_ready;
    assign in_ready     = rst_n && (state_q == PAD_ABSORB) && load;
    assign accept       = in_valid && in_ready;
    assign at_end       = (word_cnt_q == LAST_CNT);
    assign cnt_next     = at_end ? '0 : word_cnt_q + 1'b1;
    assign last_partial = in_last && (in_bytes < FULL_N);

    always_comb begin
        b_data   = in_data;
        b_n      = in_last ? in_bytes : FULL_N;
        b_ins_ds = last_partial;
        b_term   = last_partial && at_end;
        if (state_q == PAD_FILL) begin
            b_data   = '0;
            b_n      = '0;
            b_ins_ds = !ds_done_q;
            b_term   = at_end;
        end
    end

    pad_lane_builder #(
        .W  (W),
        .BW (BW)
    ) u_lane_builder (
        .data        (b_data),
        .n           (b_n),
        .ds          (ds_cur),
        .insert_ds   (b_ins_ds),
        .insert_term (b_term),
        .padded      (padded)
    );

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        ds_done_d        = ds_done_q;
        out_data_d       = out_data_q;
        out_valid_d      = out_valid_q;
        out_block_end_d  = out_block_end_q;
        out_last_block_d = out_last_block_q;
`ifdef PAD_MODE_SEL_EN
        ds_d             = ds_q;
        msg_start_d      = msg_start_q;
`endif
        if (load) begin
            out_valid_d = 1'b0;
            if (state_q == PAD_FILL) begin
                out_valid_d      = 1'b1;
                out_data_d       = padded;
                out_block_end_d  = at_end;
                out_last_block_d = 1'b1;
                word_cnt_d       = cnt_next;
                ds_done_d        = 1'b1;
                if (at_end) begin
                    state_d = PAD_ABSORB;
`ifdef PAD_MODE_SEL_EN
                    msg_start_d = 1'b1;
`endif
                end
            end else if (accept) begin
                out_valid_d      = 1'b1;
                out_data_d       = padded;
                out_block_end_d  = at_end;
                out_last_block_d = 1'b0;
                word_cnt_d       = cnt_next;
`ifdef PAD_MODE_SEL_EN
                ds_d        = ds_cur;
                msg_start_d = 1'b0;
`endif
                if (in_last) begin
                    // A full last word at block end pushes DS into a fresh block.
                    out_last_block_d = last_partial || !at_end;
                    if (last_partial && at_end) begin
`ifdef PAD_MODE_SEL_EN
                        msg_start_d = 1'b1;
`endif
                    end else begin
                        state_d   = PAD_FILL;
                        ds_done_d = last_partial;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= PAD_ABSORB;
            word_cnt_q       <= '0;
            ds_done_q        <= 1'b0;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            out_block_end_q  <= 1'b0;
            out_last_block_q <= 1'b0;
`ifdef PAD_MODE_SEL_EN
            ds_q             <= DS_SHAKE;
            msg_start_q      <= 1'b1;
`endif
        end else begin
            state_q          <= state_d;
            word_cnt_q       <= word_cnt_d;
            ds_done_q        <= ds_done_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            out_block_end_q  <= out_block_end_d;
            out_last_block_q <= out_last_block_d;
`ifdef PAD_MODE_SEL_EN
            ds_q             <= ds_d;
            msg_start_q      <= msg_start_d;
`endif
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_block_end  = out_block_end_q;
    assign out_last_block = out_last_block_q;

endmodule

// File: tb/tb_keccak_stream_padder.sv
// Self-checking bench for keccak_stream_padder: byte-level pad10*1 reference model
// feeding a scoreboard, plus directed constant checks on the documented scenarios.
module tb_keccak_stream_padder;

    localparam int W  = 64;
    localparam int R  = 17;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
`ifdef PAD_MODE_SEL_EN
    logic          mode_sha3 = 1'b0;
`endif
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_block_end;
    logic          out_last_block;

    keccak_stream_padder #(
        .W          (W),
        .RATE_WORDS (R),
        .DS_BYTE    (8'h1F)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_bytes       (in_bytes),
`ifdef PAD_MODE_SEL_EN
        .mode_sha3      (mode_sha3),
`endif
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_block_end  (out_block_end),
        .out_last_block (out_last_block)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [65:0]  exp_q[$];
    logic [63:0]  seen[$];
    logic [63:0]  msg_w[$];
    logic [7:0]   model_ds = 8'h1F;
    bit           stall_en = 1'b0;
    bit           hold_chk = 1'b0;
    logic [65:0]  held = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Values seen at the negedge are the ones the next posedge will act on.
    always @(negedge clk) begin
        logic [65:0] cur;
        logic [65:0] exp;
        cur = {out_block_end, out_last_block, out_data};
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h, required v=1 %h",
                             out_valid, cur, held);
                end
            end
            hold_chk = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                checks++;
                seen.push_back(out_data);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no output", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) begin
                        errors++;
                        $display("FAIL out_word%0d: got be/lb/data %h, required %h",
                                 seen.size() - 1, cur, exp);
                    end
                end
            end
        end
    end

    task automatic model_push(input int n);
        logic [7:0]  b[$];
        logic [63:0] w;
        int lw, nb, len, dsw, nw;
        logic be, lb;
        lw = msg_w.size() - 1;
        for (int i = 0; i <= lw; i++) begin
            w = msg_w[i];
            nb = (i == lw) ? n : NB;
            for (int j = 0; j < nb; j++) b.push_back(w[63-8*j -: 8]);
        end
        len = b.size();
        dsw = len / NB;
        b.push_back(model_ds);
        while (b.size() % (R * NB) != 0) b.push_back(8'h00);
        b[b.size()-1] = b[b.size()-1] | 8'h80;
        nw = b.size() / NB;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < NB; j++) w[63-8*j -: 8] = b[NB*k+j];
            be = (k % R == R - 1);
            if (k > lw) lb = 1'b1;
            else if (k == lw) lb = (lw / R == dsw / R);
            else lb = 1'b0;
            exp_q.push_back({be, lb, w});
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input int n);
        int waited;
        waited = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_bytes = 4'(n);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0, required 1 within 500 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input int nwords, input int n);
        msg_w.delete();
        for (int i = 0; i < nwords; i++) msg_w.push_back({$urandom, $urandom});
        model_push(n);
        for (int i = 0; i < nwords; i++) send_word(msg_w[i], i == nwords - 1, n);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_block_end, out_last_block, in_ready} !== 4'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b be=%0b lb=%0b rdy=%0b d=%h, required all 0",
                     out_valid, out_block_end, out_last_block, in_ready, out_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_partial_last();
        logic [63:0] e;
        seen.delete();
        send_msg(3, 5);
        drain();
        e = {msg_w[2][63:24], 24'h1F0000};
        checks++;
        if (seen.size() != 17 || seen[2] !== e || seen[3] !== '0 || seen[16] !== 64'h80) begin
            errors++;
            $display("FAIL partial_last: got n=%0d w2=%h w3=%h w16=%h, required 17 %h 0 80",
                     seen.size(), seen[2], seen[3], seen[16], e);
        end
    endtask

    task automatic test_exact_fill();
        logic [63:0] e;
        seen.delete();
        send_msg(17, 7);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL exact_fill_ready: got in_ready=%0b, required 1", in_ready);
        end
        drain();
        e = {msg_w[16][63:8], 8'h9F};
        checks++;
        if (seen.size() != 17 || seen[16] !== e) begin
            errors++;
            $display("FAIL exact_fill: got n=%0d w16=%h, required 17 %h",
                     seen.size(), seen[16], e);
        end
    endtask

    task automatic test_full_block_end();
        seen.delete();
        send_msg(17, 8);
        drain();
        checks++;
        if (seen.size() != 34 || seen[16] !== msg_w[16] ||
            seen[17] !== 64'h1F00_0000_0000_0000 || seen[33] !== 64'h80) begin
            errors++;
            $display("FAIL full_block_end: got n=%0d w16=%h w17=%h w33=%h, required 34 %h 1f00000000000000 80",
                     seen.size(), seen[16], seen[17], seen[33], msg_w[16]);
        end
    endtask

    task automatic test_empty();
        seen.delete();
        send_msg(1, 0);
        drain();
        checks++;
        if (seen.size() != 17 || seen[0] !== 64'h1F00_0000_0000_0000 || seen[16] !== 64'h80) begin
            errors++;
            $display("FAIL empty_msg: got n=%0d w0=%h w16=%h, required 17 1f00000000000000 80",
                     seen.size(), seen[0], seen[16]);
        end
    endtask

    task automatic test_random_stalls();
        stall_en = 1'b1;
        for (int m = 0; m < 5; m++) begin
            send_msg($urandom_range(1, 40), $urandom_range(0, 8));
            drain();
        end
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_pad();
        seen.delete();
        send_msg(1, 3);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_pad: got out_valid=%0b in_ready=%0b, required 0 0",
                     out_valid, in_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen.delete();
        send_msg(2, 8);
        drain();
        checks++;
        if (seen.size() != 17 || seen[2] !== 64'h1F00_0000_0000_0000 || seen[16] !== 64'h80) begin
            errors++;
            $display("FAIL after_reset_msg: got n=%0d w2=%h w16=%h, required 17 1f00000000000000 80",
                     seen.size(), seen[2], seen[16]);
        end
    endtask

`ifdef PAD_MODE_SEL_EN
    task automatic test_mode_sha3();
        seen.delete();
        mode_sha3 = 1'b1;
        model_ds  = 8'h06;
        send_msg(1, 0);
        mode_sha3 = 1'b0;
        drain();
        checks++;
        if (seen.size() != 17 || seen[0] !== 64'h0600_0000_0000_0000 || seen[16] !== 64'h80) begin
            errors++;
            $display("FAIL mode_sha3: got n=%0d w0=%h w16=%h, required 17 0600000000000000 80",
                     seen.size(), seen[0], seen[16]);
        end
        model_ds = 8'h1F;
    endtask
`endif

    initial begin
        test_reset();
        test_partial_last();
        test_exact_fill();
        test_full_block_end();
        test_empty();
        test_random_stalls();
        test_reset_in_pad();
`ifdef PAD_MODE_SEL_EN
        test_mode_sha3();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
